i2c_slave_resp: RTL and testbench



---
 rtl/i2c_slave_resp_pkg.sv | 22 ++
 rtl/i2c_slave_resp_if.sv | 28 ++
 rtl/i2c_slave_resp_line_cond.sv | 75 +++++++
 rtl/i2c_slave_resp.sv | 153 +++++++++++++++
 tb/tb_i2c_slave_resp.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_resp_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// position of the R/W bit in the address byte, and bus ACK/NACK levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_A,
    PTR,
    ACK_P,
    WR_DATA,
    ACK_W,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_e;

  localparam int   RW_BIT   = 0;
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_resp_if.sv
// Bus-side and register-side signals of the I2C target, plus the FSM state
// exposed for observation.
interface i2c_slave_resp_if #(
  parameter int REG_AW = 3
);
  // reg_we is a one-cycle strobe with no back-pressure: reg_addr/reg_wdata
  // are valid exactly in the cycle reg_we is high and the consumer must
  // accept the byte in that cycle.
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic              reg_we;
  logic [REG_AW-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              busy;
  logic              addr_hit;
  i2c_pkg::state_e   state;

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, reg_we, reg_addr, reg_wdata, busy, addr_hit, state
  );

  modport master (
    output scl_in, sda_in,
    input  sda_oe, reg_we, reg_addr, reg_wdata, busy, addr_hit, state
  );
endinterface

// File: rtl/i2c_slave_resp_line_cond.sv
// SCL/SDA conditioning: 2-flop synchroniser, optional glitch filter
// (I2C_SLV_GLITCH_FILTER_EN), and registered edge / START / STOP detection.
module i2c_line_cond #(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_s_o
);
  // Bit 1 carries SCL, bit 0 carries SDA throughout.
  logic [1:0] s1_q, s2_q, prev_q, filt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 2'b11;
      s2_q <= 2'b11;
    end else begin
      s1_q <= {scl_i, sda_i};
      s2_q <= s1_q;
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam int CW = $clog2(FILT_LEN + 1);
  logic [1:0]    filt_q;
  logic [CW-1:0] cnt_q [2];

  // A line only changes its filtered value after FILT_LEN consecutive
  // samples disagreeing with it; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 2'b11;
      for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CW'(FILT_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end
  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= 2'b11;
      scl_rise_o  <= 1'b0;
      scl_fall_o  <= 1'b0;
      start_det_o <= 1'b0;
      stop_det_o  <= 1'b0;
      sda_s_o     <= 1'b1;
    end else begin
      prev_q      <= filt;
      scl_rise_o  <= filt[1] & ~prev_q[1];
      scl_fall_o  <= ~filt[1] & prev_q[1];
      start_det_o <= filt[1] & prev_q[1] & prev_q[0] & ~filt[0];
      stop_det_o  <= filt[1] & prev_q[1] & ~prev_q[0] & filt[0];
      sda_s_o     <= filt[0];
    end
  end
endmodule

// File: rtl/i2c_slave_resp.sv
// I2C target with 7-bit address match, register pointer, write strobe and
// read-back from an internal register file. Glitch filter: I2C_SLV_GLITCH_FILTER_EN.
module i2c_slave_resp
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         REG_AW     = 3,
  parameter int         FILT_LEN   = 4
) (
  input  logic clk,
  input  logic reset,
  i2c_slave_resp_if.slave bus
);
  localparam int NREG = 1 << REG_AW;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_line (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (bus.scl_in),
    .sda_i      (bus.sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_s_o    (sda_s)
  );

  state_e            state_q;
  logic [3:0]        bit_cnt_q;
  logic [6:0]        shift_q;
  logic [REG_AW-1:0] ptr_q;
  logic              rw_q;
  logic              sda_oe_q, reg_we_q, busy_q, addr_hit_q;
  logic [REG_AW-1:0] reg_addr_q;
  logic [7:0]        reg_wdata_q;
  logic [7:0]        regfile_q [NREG];
  logic [7:0]        rx_byte;

  assign rx_byte = {shift_q, sda_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      addr_hit_q  <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      for (int i = 0; i < NREG; i++) regfile_q[i] <= '0;
    end else begin
      reg_we_q   <= 1'b0;
      addr_hit_q <= 1'b0;
      if (stop_det) begin
        state_q   <= IDLE;
        sda_oe_q  <= 1'b0;
        busy_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else if (start_det) begin
        state_q   <= ADDR;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          ADDR, PTR, WR_DATA: if (scl_rise) begin
            shift_q   <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR && rx_byte[7:1] != 7'h00) begin
                  addr_hit_q <= 1'b1;
                  busy_q     <= 1'b1;
                  rw_q       <= rx_byte[RW_BIT];
                  state_q    <= ACK_A;
                end else begin
                  busy_q  <= 1'b0;
                  state_q <= IGNORE;
                end
              end else if (state_q == PTR) begin
                ptr_q   <= rx_byte[REG_AW-1:0];
                state_q <= ACK_P;
              end else begin
                regfile_q[ptr_q] <= rx_byte;
                reg_we_q         <= 1'b1;
                reg_addr_q       <= ptr_q;
                reg_wdata_q      <= rx_byte;
                ptr_q            <= ptr_q + REG_AW'(1);
                state_q          <= ACK_W;
              end
            end
          end
          // sda_oe_q doubles as the ACK phase: first fall drives, second releases.
          ACK_A, ACK_P, ACK_W: if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_q <= 1'b1;
            end else begin
              bit_cnt_q <= '0;
              sda_oe_q  <= 1'b0;
              if (state_q == ACK_A && rw_q) begin
                state_q    <= RD_DATA;
                reg_addr_q <= ptr_q;
                sda_oe_q   <= ~regfile_q[ptr_q][7];
              end else if (state_q == ACK_A) begin
                state_q <= PTR;
              end else begin
                state_q <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                sda_oe_q <= ~regfile_q[ptr_q][3'd7 - bit_cnt_q[2:0]];
              end
            end
          end
          RD_ACK: if (scl_rise) begin
            bit_cnt_q <= '0;
            if (sda_s == I2C_ACK) begin
              ptr_q      <= ptr_q + REG_AW'(1);
              reg_addr_q <= ptr_q + REG_AW'(1);
              state_q    <= RD_DATA;
            end
            if (sda_s == I2C_NACK) begin
              busy_q  <= 1'b0;
              state_q <= IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_oe    = sda_oe_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.addr_hit  = addr_hit_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_i2c_slave_resp.sv
// Directed plus randomised I2C master driving the target, checked against a
// behavioural register-file/pointer model.
module tb_i2c_slave_resp;
  import i2c_pkg::*;

  localparam int         H    = 16;
  localparam int         Q    = 8;
  localparam int         NREG = 8;
  localparam logic [6:0] SLV  = 7'h42;
`ifdef I2C_SLV_GLITCH_FILTER_EN
  localparam logic GLITCH_GIVES_START = 1'b0;
`else
  localparam logic GLITCH_GIVES_START = 1'b1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_drv = 1'b1;
  logic sda_drv = 1'b1;
  always #5 clk = ~clk;

  i2c_slave_resp_if #(.REG_AW(3)) bus ();
  assign bus.scl_in = scl_drv;
  assign bus.sda_in = sda_drv & ~bus.sda_oe;

  i2c_slave_resp #(.SLAVE_ADDR(SLV), .REG_AW(3), .FILT_LEN(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  bit oe_seen = 1'b0;
  bit addr_seen = 1'b0;
  logic [10:0] exp_q[$];
  logic [7:0]  m_rf [NREG];
  int          m_ptr;
  logic [7:0]  wbuf [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_rf[i] = 8'h00;
    m_ptr = 0;
  endtask

  // Write-strobe scoreboard and event observers.
  always @(negedge clk) begin : mon
    logic [10:0] e;
    if (bus.addr_hit) hit_cnt++;
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.state == ADDR) addr_seen = 1'b1;
    if (bus.reg_we) begin
      chk("we_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("we_addr", 32'(bus.reg_addr), 32'(e[10:8]));
        chk("we_data", 32'(bus.reg_wdata), 32'(e[7:0]));
      end
    end
  end

  task automatic i2c_start();
    sda_drv = 1'b1; cyc(Q);
    scl_drv = 1'b1; cyc(H);
    sda_drv = 1'b0; cyc(H);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; cyc(Q);
    scl_drv = 1'b1; cyc(H);
    sda_drv = 1'b1; cyc(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_drv = b[i]; cyc(Q);
      scl_drv = 1'b1; cyc(H);
      scl_drv = 1'b0; cyc(Q);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic acked);
    send_bits(b, 8);
    sda_drv = 1'b1; cyc(Q);
    scl_drv = 1'b1; cyc(Q);
    acked = (bus.sda_in == I2C_ACK);
    cyc(Q);
    scl_drv = 1'b0; cyc(Q);
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] b);
    sda_drv = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      cyc(Q);
      scl_drv = 1'b1; cyc(Q);
      b[i] = bus.sda_in;
      cyc(Q);
      scl_drv = 1'b0; cyc(Q);
    end
    sda_drv = ack_bit; cyc(Q);
    scl_drv = 1'b1; cyc(H);
    scl_drv = 1'b0; cyc(Q);
    sda_drv = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] p, input int n);
    logic a;
    int   h0;
    h0 = hit_cnt;
    i2c_start();
    send_byte({SLV, 1'b0}, a); chk("wr_addr_ack", 32'(a), 1);
    chk("wr_addr_hit", hit_cnt, h0 + 1);
    chk("wr_busy", 32'(bus.busy), 1);
    send_byte(p, a); chk("wr_ptr_ack", 32'(a), 1);
    m_ptr = int'(p) % NREG;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({3'(m_ptr), wbuf[i]});
      m_rf[m_ptr] = wbuf[i];
      m_ptr = (m_ptr + 1) % NREG;
      send_byte(wbuf[i], a); chk("wr_data_ack", 32'(a), 1);
    end
    i2c_stop(); cyc(4);
    chk("wr_busy_after_stop", 32'(bus.busy), 0);
    chk("wr_all_strobes", exp_q.size(), 0);
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      send_byte({SLV, 1'b0}, a); chk("rd_waddr_ack", 32'(a), 1);
      send_byte(p, a); chk("rd_ptr_ack", 32'(a), 1);
      m_ptr = int'(p) % NREG;
      i2c_start();
    end
    send_byte({SLV, 1'b1}, a); chk("rd_addr_ack", 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? I2C_NACK : I2C_ACK, b);
      chk("rd_data", 32'(b), 32'(m_rf[m_ptr]));
      if (i != n - 1) m_ptr = (m_ptr + 1) % NREG;
    end
    cyc(H);
    chk("rd_release_after_nack", 32'(bus.sda_oe), 0);
    chk("rd_ignore_after_nack", 32'(bus.state), 32'(IGNORE));
    chk("rd_busy_after_nack", 32'(bus.busy), 0);
    i2c_stop(); cyc(4);
    chk("rd_idle_after_stop", 32'(bus.state), 32'(IDLE));
  endtask

  initial begin : stim
    logic a;
    int   h0;
    model_reset();
    cyc(5);
    chk("rst_sda_oe", 32'(bus.sda_oe), 0);
    chk("rst_reg_we", 32'(bus.reg_we), 0);
    chk("rst_reg_addr", 32'(bus.reg_addr), 0);
    chk("rst_reg_wdata", 32'(bus.reg_wdata), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_addr_hit", 32'(bus.addr_hit), 0);
    chk("rst_state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;
    cyc(10);

    // Short SDA low pulse while SCL is high.
    addr_seen = 1'b0;
    sda_drv = 1'b0; cyc(2);
    sda_drv = 1'b1; cyc(20);
    chk("glitch_start", 32'(addr_seen), 32'(GLITCH_GIVES_START));
    chk("glitch_idle", 32'(bus.state), 32'(IDLE));

    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    do_write(8'h03, 2);
    do_read(1'b1, 8'h03, 2);

    // Wrong address and general call: never acknowledged, never driven.
    h0 = hit_cnt;
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h90, a); chk("wrong_addr_nack", 32'(a), 0);
    send_byte(8'h3C, a); chk("wrong_data_nack", 32'(a), 0);
    i2c_stop();
    i2c_start();
    send_byte(8'h00, a); chk("gencall_nack", 32'(a), 0);
    i2c_stop(); cyc(4);
    chk("wrong_oe_never", 32'(oe_seen), 0);
    chk("wrong_no_hit", hit_cnt, h0);
    do_read(1'b1, 8'h03, 2);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_write(8'h07, 2);
    do_read(1'b1, 8'h07, 2);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
      do_write(8'($urandom_range(0, 255)), $urandom_range(1, 4));
    end
    do_read(1'b1, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
    do_read(1'b0, 8'h00, $urandom_range(1, 4));
    do_read(1'b0, 8'h00, $urandom_range(2, 4));

    // STOP after four data bits: pointer kept, partial byte dropped.
    i2c_start();
    send_byte({SLV, 1'b0}, a); chk("stop4_addr_ack", 32'(a), 1);
    send_byte(8'h05, a); chk("stop4_ptr_ack", 32'(a), 1);
    m_ptr = 5;
    send_bits(8'hC3, 4);
    i2c_stop(); cyc(4);
    chk("stop4_idle", 32'(bus.state), 32'(IDLE));
    chk("stop4_busy", 32'(bus.busy), 0);
    chk("stop4_sda_oe", 32'(bus.sda_oe), 0);
    do_read(1'b0, 8'h00, 1);

    // Reset while the target holds the address ACK.
    i2c_start();
    send_bits({SLV, 1'b0}, 8);
    sda_drv = 1'b1; cyc(Q);
    chk("ack_driven", 32'(bus.sda_oe), 1);
    reset = 1'b1; cyc(1);
    chk("rst_ack_sda_oe", 32'(bus.sda_oe), 0);
    chk("rst_ack_state", 32'(bus.state), 32'(IDLE));
    reset = 1'b0;
    model_reset();
    i2c_stop();

    // Reset in the middle of a data byte.
    i2c_start();
    send_byte({SLV, 1'b0}, a); chk("rstmid_addr_ack", 32'(a), 1);
    send_byte(8'h02, a); chk("rstmid_ptr_ack", 32'(a), 1);
    send_bits(8'hFF, 4);
    reset = 1'b1; cyc(1);
    chk("rstmid_sda_oe", 32'(bus.sda_oe), 0);
    chk("rstmid_state", 32'(bus.state), 32'(IDLE));
    chk("rstmid_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    model_reset();
    i2c_stop();
    do_read(1'b0, 8'h00, 3);

    cyc(10);
    chk("final_no_pending_writes", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
